// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pool_pkg
// Brief   : Shared FSM state type and pipeline latencies for the 2x2 pooling
//           controller.
// Revision: 1.0 - initial release
// ============================================================================
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RD_LAT   = 1;
  localparam int MAX_LAT  = 2;
  localparam int POOL_LAT = 3;

endpackage
`default_nettype wire

// File: rtl/pool2x2_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : pool2x2_addr_gen
// Brief   : ch/orow/ocol scan counters and top/bottom row word addresses.
// Revision: 1.0 - initial release
// ============================================================================
module pool2x2_addr_gen #(
  parameter int IN_W   = 28,
  parameter int IN_H   = 28,
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              active,
  output logic              last,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b
);

  localparam int OW = IN_W / 2;
  localparam int OH = IN_H / 2;
  localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] CH_WORDS  = ADDR_W'(IN_H * OW);

  logic [ADDR_W-1:0] ch;
  logic [ADDR_W-1:0] orow;
  logic [ADDR_W-1:0] ocol;
  logic [ADDR_W-1:0] base;
  logic              ocol_end;
  logic              orow_end;
  logic              ch_end;

  assign ocol_end = (ocol == ADDR_W'(OW - 1));
  assign orow_end = (orow == ADDR_W'(OH - 1));
  assign ch_end   = (ch == ADDR_W'(NUM_CH - 1));
  assign last     = ch_end && orow_end && ocol_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ch   <= '0;
      orow <= '0;
      ocol <= '0;
    end else if (step) begin
      if (!ocol_end) begin
        ocol <= ocol + 1'b1;
      end else begin
        ocol <= '0;
        if (!orow_end) begin
          orow <= orow + 1'b1;
        end else begin
          orow <= '0;
          ch   <= ch_end ? '0 : ch + 1'b1;
        end
      end
    end
  end

  // Each output row consumes two input rows, hence the doubled row index.
  assign base      = ch * CH_WORDS + (orow << 1) * ROW_WORDS + ocol;
  assign rd_addr_a = active ? base : '0;
  assign rd_addr_b = active ? base + ROW_WORDS : '0;

endmodule
`default_nettype wire

// File: rtl/pool2x2_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pool2x2_ctrl
// Brief   : Read/max/write sequencer for 2x2 max pooling over NUM_CH maps.
//           Optional stall counter enabled by POOL2X2_CTRL_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pool2x2_ctrl #(
  parameter int IN_W   = 28,
  parameter int IN_H   = 28,
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              max_en,
  output logic              wr_en,
`ifdef POOL2X2_CTRL_PERF_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [ADDR_W-1:0] wr_addr
);

  import pool_pkg::*;

  localparam int N = NUM_CH * (IN_H / 2) * (IN_W / 2);
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(N - 1);

  state_t              state;
  state_t              state_nxt;
  logic [POOL_LAT-1:0] vld;
  logic                start_acc;
  logic                last_issue;

  assign start_acc = (state == IDLE) && start;

  pool2x2_addr_gen #(
    .IN_W   (IN_W),
    .IN_H   (IN_H),
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .step      (rd_en),
    .active    (state == RUN),
    .last      (last_issue),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld     <= '0;
      wr_addr <= '0;
    end else begin
      state <= state_nxt;
      vld   <= {vld[POOL_LAT-2:0], rd_en};
      if (start_acc) begin
        wr_addr <= '0;
      end else if (wr_en) begin
        wr_addr <= (wr_addr == LAST_WR) ? '0 : wr_addr + 1'b1;
      end
    end
  end

  // Strobes ride a valid shift register keyed to the read issue.
  assign max_en = vld[RD_LAT-1];
  assign wr_en  = vld[RD_LAT+MAX_LAT-1];

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (last_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_en && (wr_addr == LAST_WR)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef POOL2X2_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && hold && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool2x2_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pool2x2_ctrl
// Brief   : Self-checking bench for pool2x2_ctrl (4x4x1 and 28x28x6 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pool2x2_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic hold_i = 1'b0;
  logic sel = 1'b0;

  logic s_start, s_hold, d_start, d_hold;
  assign s_start = start_i & ~sel;
  assign s_hold  = hold_i & ~sel;
  assign d_start = start_i & sel;
  assign d_hold  = hold_i & sel;

  logic s_busy, s_done, s_rd_en, s_max_en, s_wr_en;
  logic d_busy, d_done, d_rd_en, d_max_en, d_wr_en;
  logic [11:0] s_a, s_b, s_wa, d_a, d_b, d_wa;
`ifdef POOL2X2_CTRL_PERF_EN
  logic [31:0] s_stall, d_stall, o_stall;
  assign o_stall = sel ? d_stall : s_stall;
`endif

  pool2x2_ctrl #(.IN_W(4), .IN_H(4), .NUM_CH(1), .ADDR_W(12)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .hold(s_hold),
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en),
    .rd_addr_a(s_a), .rd_addr_b(s_b), .max_en(s_max_en), .wr_en(s_wr_en),
`ifdef POOL2X2_CTRL_PERF_EN
    .stall_cnt(s_stall),
`endif
    .wr_addr(s_wa)
  );

  pool2x2_ctrl u_dflt (
    .clk(clk), .rst(rst), .start(d_start), .hold(d_hold),
    .busy(d_busy), .done(d_done), .rd_en(d_rd_en),
    .rd_addr_a(d_a), .rd_addr_b(d_b), .max_en(d_max_en), .wr_en(d_wr_en),
`ifdef POOL2X2_CTRL_PERF_EN
    .stall_cnt(d_stall),
`endif
    .wr_addr(d_wa)
  );

  logic o_busy, o_done, o_rd, o_max, o_wr;
  logic [11:0] o_a, o_b, o_wa;
  assign o_busy = sel ? d_busy : s_busy;
  assign o_done = sel ? d_done : s_done;
  assign o_rd   = sel ? d_rd_en : s_rd_en;
  assign o_max  = sel ? d_max_en : s_max_en;
  assign o_wr   = sel ? d_wr_en : s_wr_en;
  assign o_a    = sel ? d_a : s_a;
  assign o_b    = sel ? d_b : s_b;
  assign o_wa   = sel ? d_wa : s_wa;

  int checks = 0;
  int failures = 0;
  bit hold_pat [0:4095];
  bit start_pat[0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pats();
    for (int i = 0; i < 4096; i++) begin
      hold_pat[i]  = 1'b0;
      start_pat[i] = 1'b0;
    end
  endtask

  // Cycle-level reference: read sequence from the pooling scan, strobes from fixed latencies.
  task automatic run(output int d_cyc, output int d_cnt, output int w_cnt, output int last_w);
    int w, h, c_n, n, k, nwr, done_c, hold_run;
    int qa[$];
    bit rdh[0:8191];
    bit e_rd, e_max, e_wr;
    w   = sel ? 28 : 4;
    h   = w;
    c_n = sel ? 6 : 1;
    n   = c_n * (h / 2) * (w / 2);
    qa.delete();
    for (int ch = 0; ch < c_n; ch++)
      for (int r = 0; r < h / 2; r++)
        for (int col = 0; col < w / 2; col++)
          qa.push_back(ch * h * (w / 2) + 2 * r * (w / 2) + col);
    k = 0; nwr = 0; done_c = -1; hold_run = 0;
    d_cyc = -1; d_cnt = 0; w_cnt = 0; last_w = -1;
    for (int c = 0; c < 8000; c++) begin
      start_i = (c == 0) || (c < 4096 && start_pat[c]);
      hold_i  = (c < 4096) && hold_pat[c];
      @(negedge clk);
      e_rd  = (c >= 1) && (k < n) && !hold_i;
      if ((c >= 1) && (k < n) && hold_i) hold_run++;
      e_max = (c >= 1) ? rdh[c-1] : 1'b0;
      e_wr  = (c >= 3) ? rdh[c-3] : 1'b0;
      rdh[c] = e_rd;
      chk("rd_en", o_rd, e_rd);
      chk("max_en", o_max, e_max);
      chk("wr_en", o_wr, e_wr);
      if (e_rd) begin
        chk("rd_addr_a", o_a, qa[k]);
        chk("rd_addr_b", o_b, qa[k] + w / 2);
        k++;
      end
      if (e_wr) begin
        chk("wr_addr", o_wa, nwr);
        if (nwr == n - 1) done_c = c + 1;
        nwr++;
      end
      chk("done", o_done, (c == done_c));
      chk("busy", o_busy, (c >= 1) && (done_c < 0 || c <= done_c));
`ifdef POOL2X2_CTRL_PERF_EN
      if (c == done_c) chk("stall_cnt", o_stall, hold_run);
`endif
      if (o_wr) begin w_cnt++; last_w = o_wa; end
      if (o_done) begin d_cnt++; if (d_cyc < 0) d_cyc = c; end
      @(posedge clk); #1;
      if (done_c >= 0 && c > done_c) break;
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
    chk("run_completed", (done_c >= 0), 1);
  endtask

  int dc, dn, wn, lw;

  initial begin
    clear_pats();
    // Reset with start asserted: reset wins.
    rst = 1'b1; start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_rd_en", o_rd, 0);
      chk("rst_max_en", o_max, 0);
      chk("rst_wr_en", o_wr, 0);
      chk("rst_rd_addr_a", o_a, 0);
      chk("rst_rd_addr_b", o_b, 0);
      chk("rst_wr_addr", o_wa, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0; sel = 1'b0;
    @(posedge clk); #1;

    // Basic 4x4x1 run.
    run(dc, dn, wn, lw);
    chk("basic_done_cycle", dc, 8);
    chk("basic_writes", wn, 4);

    // Hold in cycles 2-3.
    clear_pats(); hold_pat[2] = 1'b1; hold_pat[3] = 1'b1;
    run(dc, dn, wn, lw);
    chk("hold_done_cycle", dc, 10);

    // Repeated starts are ignored.
    clear_pats(); start_pat[3] = 1'b1; start_pat[8] = 1'b1;
    run(dc, dn, wn, lw);
    chk("restart_done_cycle", dc, 8);
    chk("restart_done_count", dn, 1);
    chk("restart_writes", wn, 4);

    // Reset in cycle 3 aborts the run.
    clear_pats();
    for (int c = 0; c < 10; c++) begin
      start_i = (c == 0);
      rst     = (c == 3);
      @(negedge clk);
      if (c >= 4) begin
        chk("abort_rd_en", o_rd, 0);
        chk("abort_max_en", o_max, 0);
        chk("abort_wr_en", o_wr, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_rd_addr_a", o_a, 0);
        chk("abort_wr_addr", o_wa, 0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; start_i = 1'b0;
    run(dc, dn, wn, lw);
    chk("post_abort_done_cycle", dc, 8);

    // Five hold cycles inside RUN.
    clear_pats();
    for (int c = 2; c < 7; c++) hold_pat[c] = 1'b1;
    run(dc, dn, wn, lw);
    chk("stall5_done_cycle", dc, 13);
`ifdef POOL2X2_CTRL_PERF_EN
    chk("stall_cnt_5", o_stall, 5);
`endif

    // Randomized hold and stray starts on the small map.
    for (int r = 0; r < 20; r++) begin
      clear_pats();
      for (int c = 0; c < 64; c++) hold_pat[c] = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 1) == 1) start_pat[$urandom_range(1, 7)] = 1'b1;
      run(dc, dn, wn, lw);
      chk("rand_done_count", dn, 1);
      chk("rand_writes", wn, 4);
    end

    // Default 28x28x6 map.
    sel = 1'b1;
    clear_pats();
    run(dc, dn, wn, lw);
    chk("dflt_done_cycle", dc, 1180);
    chk("dflt_writes", wn, 1176);
    chk("dflt_last_wr_addr", lw, 1175);
    chk("dflt_done_count", dn, 1);

    clear_pats();
    for (int c = 0; c < 2000; c++) hold_pat[c] = ($urandom_range(0, 99) < 10);
    run(dc, dn, wn, lw);
    chk("dflt_rand_writes", wn, 1176);
    chk("dflt_rand_last_wr_addr", lw, 1175);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
